// File: rtl/issue_queue.sv
// issue_queue: buffers fetched instructions and issues the oldest eligible one.
// Tracks station tags per entry and compacts the queue on writeback.
module issue_queue #(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3,
    parameter int TAG_BITS = 6,
    parameter bit IN_ORDER = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_instr,
    output logic                fetch_ready,
    input  logic [7:0]          unit_available,
    output logic                issue,
    output logic [5:0]          operation,
    output logic [2:0]          execution_unit,
    output logic [4:0]          A_address,
    output logic [4:0]          B_address,
    output logic [4:0]          Dest_address,
    input  logic                issue_accept,
    input  logic [TAG_BITS-1:0] issue_tag,
    input  logic                exec_valid,
    input  logic [TAG_BITS-1:0] exec_tag,
    input  logic                done_valid,
    input  logic [TAG_BITS-1:0] done_tag,
    output logic [PTR_BITS:0]   count,
    output logic                protocol_error
);

    typedef struct packed {
        logic [31:0]         instr;
        logic [TAG_BITS-1:0] tag;
        logic                busy;
        logic                issued;
        logic                executed;
    } entry_t;

    localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0] ONE  = (PTR_BITS+1)'(1);

    entry_t              q_r   [DEPTH];
    entry_t              q_mid [DEPTH];
    entry_t              q_nx  [DEPTH];
    logic [PTR_BITS:0]   count_r;
    logic [PTR_BITS:0]   count_nx;
    logic                perr_r;
    logic                perr_nx;
    logic [PTR_BITS-1:0] cand;
    logic                cand_found;
    logic                ex_hit;
    logic                dn_hit;
    int                  dn_idx;

    function automatic logic tag_hit(entry_t e, logic [TAG_BITS-1:0] t);
        return e.busy && e.issued && (e.tag == t);
    endfunction

    // In-order mode picks the oldest unissued entry regardless of its unit.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!cand_found && q_r[i].busy && !q_r[i].issued &&
                (IN_ORDER || unit_available[q_r[i].instr[31:29]])) begin
                cand_found = 1'b1;
                cand       = PTR_BITS'(i);
            end
        end
    end

    assign issue          = cand_found && unit_available[q_r[cand].instr[31:29]];
    assign operation      = issue ? q_r[cand].instr[31:26] : '0;
    assign execution_unit = issue ? q_r[cand].instr[31:29] : '0;
    assign A_address      = issue ? q_r[cand].instr[25:21] : '0;
    assign B_address      = issue ? q_r[cand].instr[20:16] : '0;
    assign Dest_address   = issue ? q_r[cand].instr[15:11] : '0;
    assign fetch_ready    = count_r < FULL;
    assign count          = count_r;
    assign protocol_error = perr_r;

    always_comb begin
        q_mid   = q_r;
        perr_nx = 1'b0;
        ex_hit  = 1'b0;
        dn_hit  = 1'b0;
        dn_idx  = 0;

        if (issue_accept) begin
            if (issue && issue_tag != '0) begin
                q_mid[cand].issued = 1'b1;
                q_mid[cand].tag    = issue_tag;
            end else begin
                perr_nx = 1'b1;
            end
        end

        if (exec_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!ex_hit && tag_hit(q_r[i], exec_tag)) begin
                    ex_hit             = 1'b1;
                    q_mid[i].executed = 1'b1;
                end
            end
            if (!ex_hit) perr_nx = 1'b1;
        end

        if (done_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!dn_hit && tag_hit(q_r[i], done_tag)) begin
                    dn_hit = 1'b1;
                    dn_idx = i;
                end
            end
            if (!dn_hit) perr_nx = 1'b1;
        end

        // Compaction works on post-issue state so same-edge issues move intact.
        q_nx     = q_mid;
        count_nx = count_r;
        if (dn_hit) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= dn_idx) q_nx[i] = q_mid[i+1];
            end
            q_nx[DEPTH-1] = '0;
            count_nx      = count_r - ONE;
        end

        if (fetch_valid && fetch_ready) begin
            q_nx[count_nx[PTR_BITS-1:0]] = '{
                instr:    fetch_instr,
                tag:      '0,
                busy:     1'b1,
                issued:   1'b0,
                executed: 1'b0
            };
            count_nx = count_nx + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q_r[i] <= '0;
            count_r <= '0;
            perr_r  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_r[i] <= q_nx[i];
            count_r <= count_nx;
            perr_r  <= perr_nx;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: scoreboard bench for issue_queue in both issue policies.
// Fetched words are queued as expected issues and popped on each accepted issue.
module tb_issue_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic [7:0]  unit_available = '0;
    logic        issue_accept = 1'b0;
    logic [5:0]  issue_tag = '0;
    logic        exec_valid = 1'b0;
    logic [5:0]  exec_tag = '0;
    logic        done_valid = 1'b0;
    logic [5:0]  done_tag = '0;

    logic        io_fr, io_iss, io_perr;
    logic [5:0]  io_op;
    logic [2:0]  io_eu;
    logic [4:0]  io_a, io_b, io_d;
    logic [3:0]  io_cnt;
    logic        oo_fr, oo_iss, oo_perr;
    logic [5:0]  oo_op;
    logic [2:0]  oo_eu;
    logic [4:0]  oo_a, oo_b, oo_d;
    logic [3:0]  oo_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    issue_queue #(.IN_ORDER(1'b1)) dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_ready(io_fr), .unit_available(unit_available),
        .issue(io_iss), .operation(io_op), .execution_unit(io_eu),
        .A_address(io_a), .B_address(io_b), .Dest_address(io_d),
        .issue_accept(issue_accept), .issue_tag(issue_tag),
        .exec_valid(exec_valid), .exec_tag(exec_tag),
        .done_valid(done_valid), .done_tag(done_tag),
        .count(io_cnt), .protocol_error(io_perr)
    );

    issue_queue #(.IN_ORDER(1'b0)) dut_o (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_ready(oo_fr), .unit_available(unit_available),
        .issue(oo_iss), .operation(oo_op), .execution_unit(oo_eu),
        .A_address(oo_a), .B_address(oo_b), .Dest_address(oo_d),
        .issue_accept(issue_accept), .issue_tag(issue_tag),
        .exec_valid(exec_valid), .exec_tag(exec_tag),
        .done_valid(done_valid), .done_tag(done_tag),
        .count(oo_cnt), .protocol_error(oo_perr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] u, input logic [2:0] o,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] d);
        return {u, o, a, b, d, 11'h5a5};
    endfunction

    // In-order issue always follows fetch order, so a FIFO is the reference.
    always @(negedge clock) begin
        logic [31:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (io_iss && issue_accept && issue_tag != '0) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("iss_fields", {8'h0, io_op, io_eu, io_a, io_b, io_d},
                          {8'h0, e[31:26], e[31:29], e[25:21], e[20:16], e[15:11]});
                end
            end
            if (fetch_valid && io_fr) exp_q.push_back(fetch_instr);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fetch_valid  = 1'b0;
        issue_accept = 1'b0;
        exec_valid   = 1'b0;
        done_valid   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        #2;
        check("rst_count", 32'(io_cnt), 32'd0);
        check("rst_ready", 32'(io_fr), 32'd1);
        check("rst_issue", 32'(io_iss), 32'd0);
        check("rst_op", 32'(io_op), 32'd0);
        check("rst_perr", 32'(io_perr), 32'd0);

        // Fill to capacity with nothing available, then try a ninth fetch.
        unit_available = 8'h00;
        fetch_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fetch_instr = mk(3'd0, 3'(k), 5'(k), 5'(k + 1), 5'(k + 2));
            cyc();
        end
        fetch_instr = mk(3'd0, 3'd7, 5'd31, 5'd31, 5'd31);
        #2;
        check("full_count", 32'(io_cnt), 32'd8);
        check("full_ready", 32'(io_fr), 32'd0);
        check("full_noissue", 32'(io_iss), 32'd0);
        cyc();
        fetch_valid = 1'b0;
        #2;
        check("refused_count", 32'(io_cnt), 32'd8);

        unit_available = 8'h01;
        issue_accept = 1'b1;
        for (int k = 0; k < 8; k++) begin
            issue_tag = 6'(k + 1);
            cyc();
        end
        issue_accept = 1'b0;
        #2;
        check("all_issued", 32'(io_iss), 32'd0);

        // A done does not make room for a same-cycle fetch.
        fetch_valid = 1'b1;
        fetch_instr = mk(3'd1, 3'd1, 5'd1, 5'd1, 5'd1);
        done_valid = 1'b1;
        done_tag = 6'd8;
        cyc();
        idle();
        #2;
        check("full_done_cnt", 32'(io_cnt), 32'd7);
        check("full_done_perr", 32'(io_perr), 32'd0);

        // Blocking versus out-of-order selection on identical contents.
        do_reset();
        unit_available = 8'h01;
        fetch_valid = 1'b1;
        fetch_instr = mk(3'd2, 3'd1, 5'd1, 5'd2, 5'd3);
        cyc();
        fetch_instr = mk(3'd0, 3'd2, 5'd4, 5'd5, 5'd6);
        cyc();
        fetch_valid = 1'b0;
        #2;
        check("io_block", 32'(io_iss), 32'd0);
        check("oo_issue", 32'(oo_iss), 32'd1);
        check("oo_unit", 32'(oo_eu), 32'd0);
        check("oo_op", 32'(oo_op), 32'h02);
        check("oo_regs", 32'({oo_a, oo_b, oo_d}), 32'({5'd4, 5'd5, 5'd6}));

        issue_accept = 1'b1;
        issue_tag = 6'd5;
        cyc();
        issue_accept = 1'b0;
        #2;
        check("io_acc_err", 32'(io_perr), 32'd1);
        check("io_err_cnt", 32'(io_cnt), 32'd2);
        check("oo_acc_ok", 32'(oo_perr), 32'd0);
        check("oo_next_blk", 32'(oo_iss), 32'd0);
        cyc();
        #2;
        check("io_err_pulse", 32'(io_perr), 32'd0);

        unit_available = 8'h05;
        #2;
        check("io_unblock", 32'(io_iss), 32'd1);
        check("io_unit2", 32'(io_eu), 32'd2);
        check("oo_next", 32'(oo_iss), 32'd1);
        check("oo_next_unit", 32'(oo_eu), 32'd2);

        done_valid = 1'b1;
        done_tag = 6'd5;
        cyc();
        idle();
        #2;
        check("oo_done_cnt", 32'(oo_cnt), 32'd1);
        check("oo_done_perr", 32'(oo_perr), 32'd0);
        check("io_nodone_perr", 32'(io_perr), 32'd1);
        check("io_nodone_cnt", 32'(io_cnt), 32'd2);

        issue_accept = 1'b1;
        issue_tag = 6'd3;
        cyc();
        issue_tag = 6'd4;
        cyc();
        issue_accept = 1'b0;
        #2;
        check("io_drained", 32'(io_iss), 32'd0);

        // Middle retirement with same-cycle fetch, then a full drain.
        do_reset();
        unit_available = 8'hff;
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fetch_instr = mk(3'(k + 1), 3'(k), 5'(k + 10), 5'(k + 11), 5'(k + 12));
            cyc();
        end
        fetch_valid = 1'b0;
        issue_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_tag = 6'(k + 1);
            cyc();
        end
        issue_accept = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = mk(3'd6, 3'd5, 5'd20, 5'd21, 5'd22);
        done_valid = 1'b1;
        done_tag = 6'd2;
        cyc();
        idle();
        #2;
        check("mid_count", 32'(io_cnt), 32'd4);
        check("mid_perr", 32'(io_perr), 32'd0);
        check("mid_cand", 32'(io_eu), 32'd6);

        issue_accept = 1'b1;
        issue_tag = 6'd6;
        cyc();
        idle();
        exec_valid = 1'b1;
        exec_tag = 6'd1;
        cyc();
        idle();
        #2;
        check("exec_ok", 32'(io_perr), 32'd0);
        exec_valid = 1'b1;
        exec_tag = 6'd2;
        cyc();
        idle();
        #2;
        check("exec_gone", 32'(io_perr), 32'd1);
        done_valid = 1'b1;
        done_tag = 6'd3;
        cyc();
        idle();
        #2;
        check("done3_cnt", 32'(io_cnt), 32'd3);
        check("done3_perr", 32'(io_perr), 32'd0);

        fetch_valid = 1'b1;
        fetch_instr = mk(3'd7, 3'd2, 5'd7, 5'd8, 5'd9);
        cyc();
        idle();
        issue_accept = 1'b1;
        issue_tag = 6'd2;
        done_valid = 1'b1;
        done_tag = 6'd1;
        cyc();
        idle();
        #2;
        check("accdone_cnt", 32'(io_cnt), 32'd3);
        check("accdone_perr", 32'(io_perr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            done_valid = 1'b1;
            done_tag = (k == 0) ? 6'd2 : (k == 1) ? 6'd4 : 6'd6;
            cyc();
            idle();
            #2;
            check("drain_perr", 32'(io_perr), 32'd0);
            check("drain_cnt", 32'(io_cnt), 32'(2 - k));
        end
        done_valid = 1'b1;
        done_tag = 6'd7;
        cyc();
        idle();
        #2;
        check("empty_done_perr", 32'(io_perr), 32'd1);
        check("empty_done_cnt", 32'(io_cnt), 32'd0);

        // Zero tag is illegal, then a reset discards in-flight work.
        do_reset();
        unit_available = 8'hff;
        fetch_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fetch_instr = mk(3'(k), 3'(k + 2), 5'(k), 5'(k), 5'(k));
            cyc();
        end
        fetch_valid = 1'b0;
        issue_accept = 1'b1;
        issue_tag = 6'd0;
        cyc();
        idle();
        #2;
        check("tag0_perr", 32'(io_perr), 32'd1);
        issue_accept = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue_tag = 6'(k + 1);
            cyc();
        end
        issue_accept = 1'b0;
        #2;
        check("pre_rst_cnt", 32'(io_cnt), 32'd5);
        do_reset();
        #2;
        check("mrst_count", 32'(io_cnt), 32'd0);
        check("mrst_issue", 32'(io_iss), 32'd0);
        check("mrst_ready", 32'(io_fr), 32'd1);
        check("mrst_oo_cnt", 32'(oo_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
